// File: rtl/text_pkg.sv
// Shared constants for the text console: screen size defaults,
// control-character codes and the cursor writer state encoding.
package text_pkg;

    localparam int COLS_DEF = 32;
    localparam int ROWS_DEF = 4;

    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_BLANK = 8'h20;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/screen_sweep_counter.sv
// Row-major cell counter over a ROWS x COLS screen.
// Ports: start (restart at 0,0), row/col (current cell), last (final cell).
module screen_sweep_counter #(
    parameter int ROWS = 4,
    parameter int COLS = 32,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last
);

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          run_q, run_d;

    logic row_end;
    logic col_end;

    assign row_end = (row_q == RW'(ROWS - 1));
    assign col_end = (col_q == CW'(COLS - 1));

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        run_d = run_q;
        if (start) begin
            row_d = '0;
            col_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            if (col_end) begin
                col_d = '0;
                if (row_end) begin
                    row_d = '0;
                    run_d = 1'b0;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_q <= '0;
            col_q <= '0;
            run_q <= 1'b0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            run_q <= run_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign last = run_q & row_end & col_end;

endmodule

// File: rtl/text_cursor_writer.sv
// UART byte stream to text-RAM write commands with cursor tracking.
// Ports: rx_* (byte in), clr (clear), wr_* (RAM write), cur_* / busy (status).
module text_cursor_writer
    import text_pkg::*;
#(
    parameter int         COLS     = COLS_DEF,
    parameter int         ROWS     = ROWS_DEF,
    parameter int         HOME_COL = 0,
    parameter int         HOME_ROW = 0,
    parameter logic [7:0] BLANK    = CH_BLANK,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    input  logic          clr,
    output logic          wr_en,
    output logic [RW-1:0] wr_row,
    output logic [CW-1:0] wr_col,
    output logic [7:0]    wr_data,
    output logic [RW-1:0] cur_row,
    output logic [CW-1:0] cur_col,
    output logic          busy
);

    state_e        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          prev_cr_q, prev_cr_d;
    logic          wr_en_q, wr_en_d;
    logic [RW-1:0] wr_row_q, wr_row_d;
    logic [CW-1:0] wr_col_q, wr_col_d;
    logic [7:0]    wr_data_q, wr_data_d;

    logic          sweep_start;
    logic [RW-1:0] sweep_row;
    logic [CW-1:0] sweep_col;
    logic          sweep_last;

    logic          accept;
    logic          is_print;
    logic [RW-1:0] row_inc;

    screen_sweep_counter #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_sweep (
        .clk   (clk),
        .reset (reset),
        .start (sweep_start),
        .row   (sweep_row),
        .col   (sweep_col),
        .last  (sweep_last)
    );

    assign rx_ready = (state_q == IDLE) & ~clr;
    assign accept   = rx_valid & rx_ready;
    assign is_print = (rx_data >= 8'h20) & (rx_data <= 8'h7E);
    assign row_inc  = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        prev_cr_d   = prev_cr_q;
        wr_en_d     = 1'b0;
        wr_row_d    = wr_row_q;
        wr_col_d    = wr_col_q;
        wr_data_d   = wr_data_q;
        sweep_start = 1'b0;
        if (clr) begin
            // A clear always (re)starts the sweep from (0,0).
            state_d     = CLEAR;
            sweep_start = 1'b1;
        end else if (state_q == CLEAR) begin
            if (sweep_last) begin
                state_d   = IDLE;
                row_d     = RW'(HOME_ROW);
                col_d     = CW'(HOME_COL);
                prev_cr_d = 1'b0;
            end
        end else if (accept) begin
            prev_cr_d = 1'b0;
            unique case (1'b1)
                is_print: begin
                    wr_en_d   = 1'b1;
                    wr_row_d  = row_q;
                    wr_col_d  = col_q;
                    wr_data_d = rx_data;
                    if (col_q == CW'(COLS - 1)) begin
                        col_d = '0;
                        row_d = row_inc;
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
                (rx_data == CH_CR): begin
                    row_d     = row_inc;
                    col_d     = CW'(HOME_COL);
                    prev_cr_d = 1'b1;
                end
                (rx_data == CH_LF): begin
                    // LF directly after CR is part of a CRLF pair.
                    if (!prev_cr_q) begin
                        row_d = row_inc;
                        col_d = CW'(HOME_COL);
                    end
                end
                (rx_data == CH_BS): begin
                    if (col_q != '0) begin
                        col_d     = col_q - CW'(1);
                        wr_en_d   = 1'b1;
                        wr_row_d  = row_q;
                        wr_col_d  = col_q - CW'(1);
                        wr_data_d = BLANK;
                    end else if (row_q != '0) begin
                        row_d     = row_q - RW'(1);
                        col_d     = CW'(COLS - 1);
                        wr_en_d   = 1'b1;
                        wr_row_d  = row_q - RW'(1);
                        wr_col_d  = CW'(COLS - 1);
                        wr_data_d = BLANK;
                    end
                end
                (rx_data == CH_FF): begin
                    state_d     = CLEAR;
                    sweep_start = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            row_q     <= RW'(HOME_ROW);
            col_q     <= CW'(HOME_COL);
            prev_cr_q <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_row_q  <= '0;
            wr_col_q  <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            prev_cr_q <= prev_cr_d;
            wr_en_q   <= wr_en_d;
            wr_row_q  <= wr_row_d;
            wr_col_q  <= wr_col_d;
            wr_data_q <= wr_data_d;
        end
    end

    // During a sweep the write port is fed straight from the counter flops.
    assign busy    = (state_q == CLEAR);
    assign wr_en   = busy | wr_en_q;
    assign wr_row  = busy ? sweep_row : wr_row_q;
    assign wr_col  = busy ? sweep_col : wr_col_q;
    assign wr_data = busy ? BLANK : wr_data_q;
    assign cur_row = row_q;
    assign cur_col = col_q;

endmodule

// File: tb/tb_text_cursor_writer.sv
// Scoreboard bench for text_cursor_writer: randomized and directed
// bytes checked against a linear-position screen model.
module tb_text_cursor_writer;

    localparam int COLS = 32;
    localparam int ROWS = 4;
    localparam int N    = ROWS * COLS;
    localparam logic [7:0] BL = 8'h20;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       clr;
    logic       wr_en;
    logic [1:0] wr_row;
    logic [4:0] wr_col;
    logic [7:0] wr_data;
    logic [1:0] cur_row;
    logic [4:0] cur_col;
    logic       busy;

    always #5 clk = ~clk;

    text_cursor_writer dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .clr      (clr),
        .wr_en    (wr_en),
        .wr_row   (wr_row),
        .wr_col   (wr_col),
        .wr_data  (wr_data),
        .cur_row  (cur_row),
        .cur_col  (cur_col),
        .busy     (busy)
    );

    typedef struct {
        int         r;
        int         c;
        logic [7:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  pos      = 0;
    bit  prev_cr  = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_push(input int p, input logic [7:0] d);
        wr_t e;
        e.r = p / COLS;
        e.c = p % COLS;
        e.d = d;
        exp_q.push_back(e);
    endfunction

    function automatic void m_clear(input int cells);
        for (int i = 0; i < cells; i++) m_push(i, BL);
        pos     = 0;
        prev_cr = 0;
    endfunction

    function automatic int m_newline(input int p);
        return ((p / COLS + 1) % ROWS) * COLS;
    endfunction

    function automatic void m_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            m_push(pos, b);
            pos     = (pos + 1) % N;
            prev_cr = 0;
        end else if (b == 8'h0D) begin
            pos     = m_newline(pos);
            prev_cr = 1;
        end else if (b == 8'h0A) begin
            if (!prev_cr) pos = m_newline(pos);
            prev_cr = 0;
        end else if (b == 8'h08) begin
            if (pos > 0) begin
                pos = pos - 1;
                m_push(pos, BL);
            end
            prev_cr = 0;
        end else if (b == 8'h0C) begin
            m_clear(N);
        end else begin
            prev_cr = 0;
        end
    endfunction

    always @(negedge clk) begin
        if (reset && wr_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_row", int'(wr_row), e.r);
                chk("wr_col", int'(wr_col), e.c);
                chk("wr_data", int'(wr_data), int'(e.d));
            end
        end
        if (reset && busy) chk("rdy_in_sweep", int'(rx_ready), 0);
    end

    task automatic check_cursor(input string name);
        chk({name, "_row"}, int'(cur_row), pos / COLS);
        chk({name, "_col"}, int'(cur_col), pos % COLS);
    endtask

    task automatic send(input logic [7:0] b, input bit with_clr);
        int budget;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        clr      = with_clr;
        #1;
        if (with_clr) begin
            chk("rdy_with_clr", int'(rx_ready), 0);
            m_clear(N);
            @(negedge clk);
            clr = 1'b0;
            #1;
        end
        budget = 400;
        while (!rx_ready && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        if (budget == 0) begin
            chk("accept_timeout", 0, 1);
            rx_valid = 1'b0;
            return;
        end
        m_byte(b);
        @(negedge clk);
        rx_valid = 1'b0;
        if (b >= 8'h20 && b <= 8'h7E) chk("wr_latency", int'(wr_en), 1);
        if (b != 8'h0C) check_cursor("cur");
    endtask

    task automatic pulse_clr(input int cells);
        @(negedge clk);
        clr = 1'b1;
        m_clear(cells);
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i], 1'b0);
    endtask

    initial begin
        int         cnt;
        int         k;
        int         r;
        logic [7:0] b;

        reset    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        clr      = 1'b0;
        #3;
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_wr_row", int'(wr_row), 0);
        chk("rst_wr_col", int'(wr_col), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        chk("rst_busy", int'(busy), 0);
        check_cursor("rst_cur");
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_rdy", int'(rx_ready), 1);

        send_str("AB");
        for (int i = 0; i < 33; i++) send(8'(i + 8'h30), 1'b0);
        pulse_clr(N);
        chk("busy_on", int'(busy), 1);
        wait_idle(cnt);
        chk("sweep_len", cnt, N);
        check_cursor("after_clr");

        for (int i = 0; i < N; i++) send(8'h61 + 8'(i % 26), 1'b0);
        send(8'h7E, 1'b0);

        pulse_clr(N);
        wait_idle(cnt);
        send_str("hello");
        send(8'h0D, 1'b0);
        send(8'h0A, 1'b0);
        send_str("abc");
        send(8'h0A, 1'b0);
        send(8'h0D, 1'b0);
        send(8'h0D, 1'b0);
        send(8'h0D, 1'b0);
        send(8'h0D, 1'b0);
        send(8'h08, 1'b0);
        pulse_clr(N);
        wait_idle(cnt);
        send(8'h08, 1'b0);
        chk("bs_home_no_wr", int'(wr_en), 0);

        k = $urandom_range(5, 40);
        pulse_clr(k);
        repeat (k - 2) @(negedge clk);
        pulse_clr(N);
        wait_idle(cnt);
        chk("restart_len", cnt, N);
        check_cursor("after_restart");

        send(8'h31, 1'b0);
        send(8'h5A, 1'b1);
        send(8'h0C, 1'b0);
        send(8'h42, 1'b0);

        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 99);
            if (r < 60) b = 8'($urandom_range(32, 126));
            else if (r < 70) b = 8'h0D;
            else if (r < 80) b = 8'h0A;
            else if (r < 90) b = 8'h08;
            else if (r < 92) b = 8'h0C;
            else b = 8'($urandom_range(127, 255));
            send(b, $urandom_range(0, 40) == 0);
        end

        pulse_clr(11);
        repeat (10) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_wr_en", int'(wr_en), 0);
        chk("arst_busy", int'(busy), 0);
        exp_q.delete();
        pos     = 0;
        prev_cr = 0;
        check_cursor("arst_cur");
        @(negedge clk);
        reset = 1'b1;
        send(8'h01, 1'b0);
        send(8'h7F, 1'b0);
        chk("drop_no_wr", int'(wr_en), 0);

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
